// File: rtl/sprite_renderer_if.sv
// rtl/sprite_renderer_if.sv - sprite ROM read bus between renderer (master) and external ROM (slave)
interface sprite_renderer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;

  modport master (output o_rom_addr, input i_rom_data);
  modport slave  (input o_rom_addr, output i_rom_data);
endinterface

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - ROM-backed sprite overlay with runtime position, scale, colour key and blink
// Pipeline: region test at t, ROM address at t+1, pixel/flag out at t+2+ROM_LAT.
module sprite_renderer #(
  parameter int SPR_W      = 480,
  parameter int SPR_H      = 360,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_KEY = 0,
  parameter int BLINK_FR   = 30
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        xx,
  input  logic [9:0]        yy,
  input  logic              aactive,
  input  logic [9:0]        i_pos_x,
  input  logic [9:0]        i_pos_y,
  input  logic              i_pos_we,
  input  logic              i_enable,
  input  logic              i_blink,
  sprite_renderer_if.master rom,
  output logic              GSpriteOn,
  output logic [DATA_W-1:0] dataout
);
  localparam int SR_W = ROM_LAT + 1;
  localparam logic [11:0] REG_W = 12'(SPR_W << SCALE_LOG2);
  localparam logic [11:0] REG_H = 12'(SPR_H << SCALE_LOG2);

  logic [9:0]      pend_x, pend_y, act_x, act_y;
  logic            en_act, blk_act, visible;
  logic [7:0]      frame_cnt;
  logic [SR_W-1:0] hit_sr;

  logic [11:0]       x12, y12, px12, py12, dx12, dy12;
  logic              frame_start, in_x, in_y, hit;
  logic [ADDR_W-1:0] col, row, addr_next;

  // 12-bit compares keep a region running past the screen edge from wrapping.
  always_comb begin
    x12         = {2'b00, xx};
    y12         = {2'b00, yy};
    px12        = {2'b00, act_x};
    py12        = {2'b00, act_y};
    dx12        = x12 - px12;
    dy12        = y12 - py12;
    frame_start = (xx == 10'd0) && (yy == 10'd0);
    in_x        = (x12 >= px12) && (x12 < px12 + REG_W);
    in_y        = (y12 >= py12) && (y12 < py12 + REG_H);
    hit         = aactive && en_act && visible && in_x && in_y;
    col         = ADDR_W'(dx12 >> SCALE_LOG2);
    row         = ADDR_W'(dy12 >> SCALE_LOG2);
    addr_next   = row * ADDR_W'(SPR_W) + col;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_x         <= '0;
      pend_y         <= '0;
      act_x          <= '0;
      act_y          <= '0;
      en_act         <= 1'b0;
      blk_act        <= 1'b0;
      visible        <= 1'b1;
      frame_cnt      <= '0;
      hit_sr         <= '0;
      rom.o_rom_addr <= '0;
      GSpriteOn      <= 1'b0;
      dataout        <= '0;
    end else begin
      if (i_pos_we) begin
        pend_x <= i_pos_x;
        pend_y <= i_pos_y;
      end
      if (frame_start) begin
        act_x   <= pend_x;
        act_y   <= pend_y;
        en_act  <= i_enable;
        blk_act <= i_blink;
        // Counting starts on the frame after blink first becomes active.
        if (!i_blink || !blk_act) begin
          frame_cnt <= '0;
          visible   <= 1'b1;
        end else if (frame_cnt == 8'(BLINK_FR - 1)) begin
          frame_cnt <= '0;
          visible   <= ~visible;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
      if (hit) rom.o_rom_addr <= addr_next;
      hit_sr    <= {hit_sr[SR_W-2:0], hit};
      GSpriteOn <= hit_sr[SR_W-1] && (rom.i_rom_data != DATA_W'(TRANSP_KEY));
      dataout   <= hit_sr[SR_W-1] ? rom.i_rom_data : '0;
    end
  end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - directed bench: full-size sprite (a) and 4x4 scaled-by-2 sprite (b)
module tb_sprite_renderer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xx = 10'd700, yy = 10'd500;
  logic       aactive = 1'b0;
  logic [9:0] pos_ax = '0, pos_ay = '0;
  logic [9:0] pos_bx = 10'd10, pos_by = 10'd10;
  logic       pos_we = 1'b0, enable = 1'b1, blink = 1'b0;
  logic [7:0] rom_val = 8'h5A;
  logic       on_a, on_b;
  logic [7:0] data_a, data_b;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  sprite_renderer_if #(.ADDR_W(18), .DATA_W(8)) rom_a ();
  sprite_renderer_if #(.ADDR_W(18), .DATA_W(8)) rom_b ();

  // One-clock ROM whose contents are rom_val XOR the address low byte.
  always_ff @(posedge clk) begin
    rom_a.i_rom_data <= rom_val ^ rom_a.o_rom_addr[7:0];
    rom_b.i_rom_data <= rom_val ^ rom_b.o_rom_addr[7:0];
  end

  sprite_renderer #(.BLINK_FR(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
    .i_pos_x(pos_ax), .i_pos_y(pos_ay), .i_pos_we(pos_we), .i_enable(enable),
    .i_blink(blink), .rom(rom_a.master), .GSpriteOn(on_a), .dataout(data_a)
  );

  sprite_renderer #(.SPR_W(4), .SPR_H(4), .SCALE_LOG2(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
    .i_pos_x(pos_bx), .i_pos_y(pos_by), .i_pos_we(pos_we), .i_enable(enable),
    .i_blink(blink), .rom(rom_b.master), .GSpriteOn(on_b), .dataout(data_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int x, input int y, input logic act);
    xx = 10'(x);
    yy = 10'(y);
    aactive = act;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(700, 500, 1'b0);
  endtask

  task automatic frame_start();
    cyc(0, 0, 1'b0);
  endtask

  task automatic load_pos(input int ax, input int ay);
    pos_ax = 10'(ax);
    pos_ay = 10'(ay);
    pos_we = 1'b1;
    idle();
    pos_we = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic hit_a, input int addr_a,
                       input logic hit_b, input int addr_b);
    logic [17:0] aa, ab;
    logic [7:0]  da, db;
    aa = 18'(addr_a);
    ab = 18'(addr_b);
    da = hit_a ? (rom_val ^ aa[7:0]) : 8'h00;
    db = hit_b ? (rom_val ^ ab[7:0]) : 8'h00;
    cyc(x, y, 1'b1);
    chk({tag, ".addr_a"}, 32'(rom_a.o_rom_addr), 32'(aa));
    chk({tag, ".addr_b"}, 32'(rom_b.o_rom_addr), 32'(ab));
    idle();
    idle();
    chk({tag, ".on_a"}, 32'(on_a), 32'(hit_a && da != 8'h00));
    chk({tag, ".data_a"}, 32'(data_a), 32'(da));
    chk({tag, ".on_b"}, 32'(on_b), 32'(hit_b && db != 8'h00));
    chk({tag, ".data_b"}, 32'(data_b), 32'(db));
  endtask

  initial begin
    idle();
    idle();
    chk("rst.addr_a", 32'(rom_a.o_rom_addr), 32'd0);
    chk("rst.on_a", 32'(on_a), 32'd0);
    chk("rst.data_a", 32'(data_a), 32'd0);
    chk("rst.on_b", 32'(on_b), 32'd0);
    rst = 1'b0;
    idle();

    load_pos(80, 60);
    frame_start();
    probe("t1.origin", 80, 60, 1'b1, 0, 1'b0, 0);
    probe("t1.corner", 559, 419, 1'b1, 172799, 1'b0, 0);
    probe("t1.left", 79, 60, 1'b0, 172799, 1'b0, 0);
    probe("t1.right", 560, 60, 1'b0, 172799, 1'b0, 0);

    probe("t2.p10", 10, 10, 1'b0, 172799, 1'b1, 0);
    probe("t2.p11", 11, 11, 1'b0, 172799, 1'b1, 0);
    probe("t2.p17", 17, 17, 1'b0, 172799, 1'b1, 15);
    probe("t2.p18", 18, 10, 1'b0, 172799, 1'b0, 15);

    rom_val = 8'h00;
    probe("t3.key", 80, 60, 1'b1, 0, 1'b0, 15);
    rom_val = 8'h01;
    probe("t3.opaque", 80, 60, 1'b1, 0, 1'b0, 15);
    rom_val = 8'h5A;

    load_pos(200, 100);
    probe("t4.old_origin", 80, 60, 1'b1, 0, 1'b0, 15);
    probe("t4.old_new", 200, 100, 1'b1, 19320, 1'b0, 15);
    frame_start();
    probe("t4.new_origin", 200, 100, 1'b1, 0, 1'b0, 15);
    probe("t4.new_left", 199, 100, 1'b0, 0, 1'b0, 15);
    load_pos(600, 450);
    frame_start();
    probe("t4.clip", 639, 479, 1'b1, 13959, 1'b0, 15);
    probe("t4.nowrap", 0, 450, 1'b0, 13959, 1'b0, 15);

    load_pos(80, 60);
    blink = 1'b1;
    frame_start();
    probe("t5.f0", 81, 61, 1'b1, 481, 1'b0, 15);
    frame_start();
    probe("t5.f1", 81, 61, 1'b1, 481, 1'b0, 15);
    frame_start();
    probe("t5.f2", 80, 60, 1'b0, 481, 1'b0, 15);
    frame_start();
    probe("t5.f3", 80, 60, 1'b0, 481, 1'b0, 15);
    frame_start();
    probe("t5.f4", 81, 61, 1'b1, 481, 1'b0, 15);
    frame_start();
    probe("t5.f5", 81, 61, 1'b1, 481, 1'b0, 15);
    blink = 1'b0;
    frame_start();
    probe("t5.off6", 81, 61, 1'b1, 481, 1'b0, 15);
    frame_start();
    probe("t5.off7", 81, 61, 1'b1, 481, 1'b0, 15);

    cyc(80, 60, 1'b1);
    cyc(81, 60, 1'b1);
    rst = 1'b1;
    cyc(82, 60, 1'b1);
    chk("t6.on_a", 32'(on_a), 32'd0);
    chk("t6.data_a", 32'(data_a), 32'd0);
    chk("t6.addr_a", 32'(rom_a.o_rom_addr), 32'd0);
    chk("t6.addr_b", 32'(rom_b.o_rom_addr), 32'd0);
    rst = 1'b0;
    idle();
    probe("t6.before_fs", 81, 61, 1'b0, 0, 1'b0, 0);
    load_pos(80, 60);
    frame_start();
    probe("t6.after_fs", 81, 61, 1'b1, 481, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
